uart_tx_fifo: RTL

- Parametrised UART transmitter; successor to the fixed 8-bit single-shot tx.
- Configurable data width, parity mode and stop-bit count.
- Built-in write FIFO, so a host can queue several characters and they go out back-to-back with no idle gap.
- Sits between the host/bus logic and the board TX pin.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 58 +++++
 rtl/uart_tx_fifo.sv | 139 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the FIFO-fed UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_mode_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  function automatic int baud_clocks(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO; rdata is a register that always
// holds the head entry whenever empty is low.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic             do_push, do_pop;

  // Flags are pre-edge: a push while full is dropped even if a pop happens too.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    rd_nxt  = do_pop ? rd_ptr + 1'b1 : rd_ptr;
    cnt_nxt = count + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      rdata  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_nxt;
      count  <= cnt_nxt;
      full   <= (cnt_nxt == CW'(DEPTH));
      empty  <= (cnt_nxt == '0);
      // The new head is the incoming word when it lands in the head slot.
      rdata  <= (do_push && (wr_ptr == rd_nxt)) ? wdata : mem[rd_nxt];
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Parametrised UART transmitter fed by a write FIFO; queued characters are
// sent back-to-back. tx_out is registered one cycle behind the FSM state.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE     = 19_200,
  parameter int DATA_BITS     = 8,
  parameter int PARITY_MODE   = 0,
  parameter int STOP_BITS     = 1,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [DATA_BITS-1:0]          din,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          tx_out,
  output logic                          busy
);

  localparam int           BAUD_CLOCKS = baud_clocks(CLK_FREQUENCY, BAUD_RATE);
  localparam int           BW          = (BAUD_CLOCKS > 1) ? $clog2(BAUD_CLOCKS) : 1;
  localparam parity_mode_t PMODE       = parity_mode_t'(PARITY_MODE);

  tx_state_t            state, state_nxt;
  logic [BW-1:0]        baud_cnt, baud_nxt;
  logic [2:0]           bit_cnt, bit_nxt;
  logic [DATA_BITS-1:0] shreg, sh_nxt, rdata;
  logic                 par_bit, par_nxt;
  logic                 tx_nxt, pop, bit_end;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_en),
    .pop   (pop),
    .wdata (din),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign bit_end = (baud_cnt == BW'(BAUD_CLOCKS - 1));

  always_comb begin
    state_nxt = state;
    baud_nxt  = bit_end ? '0 : baud_cnt + 1'b1;
    bit_nxt   = bit_cnt;
    sh_nxt    = shreg;
    par_nxt   = par_bit;
    pop       = 1'b0;
    tx_nxt    = 1'b1;
    case (state)
      IDLE: begin
        baud_nxt = '0;
        if (!empty) begin
          pop       = 1'b1;
          sh_nxt    = rdata;
          par_nxt   = (^rdata) ^ (PMODE == PAR_ODD);
          state_nxt = START;
        end
      end
      START: begin
        tx_nxt = 1'b0;
        if (bit_end) begin
          bit_nxt   = '0;
          state_nxt = DATA;
        end
      end
      DATA: begin
        tx_nxt = shreg[0];
        if (bit_end) begin
          sh_nxt  = shreg >> 1;
          bit_nxt = bit_cnt + 1'b1;
          if (bit_cnt == 3'(DATA_BITS - 1)) begin
            bit_nxt   = '0;
            state_nxt = (PMODE == PAR_NONE) ? STOP : PARITY;
          end
        end
      end
      PARITY: begin
        tx_nxt = par_bit;
        if (bit_end) begin
          bit_nxt   = '0;
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          bit_nxt = bit_cnt + 1'b1;
          if (bit_cnt == 3'(STOP_BITS - 1)) begin
            bit_nxt = '0;
            // Chain straight into the next start bit when more data is queued.
            if (!empty) begin
              pop       = 1'b1;
              sh_nxt    = rdata;
              par_nxt   = (^rdata) ^ (PMODE == PAR_ODD);
              state_nxt = START;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      tx_out   <= 1'b1;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      shreg    <= sh_nxt;
      par_bit  <= par_nxt;
      tx_out   <= tx_nxt;
      busy     <= (state != IDLE) || !empty;
      overflow <= wr_en && full;
    end
  end

endmodule
